mux2_arbiter: RTL and testbench
===============================

MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of both requester ports and the output port.
REQ-002 clk  input  1  Sole clock; all state updates on posedge clk.
REQ-003 resetn  input  1  Synchronous, active-low reset; sampled on posedge clk.
REQ-004 a_valid  input  1  Requester A holds a byte.
REQ-005 a  input  WIDTH  Requester A data.
REQ-006 a_ready  output  1  Requester A byte accepted this cycle.
REQ-007 b_valid  input  1  Requester B holds a byte.
REQ-008 b  input  WIDTH  Requester B data.
REQ-009 b_ready  output  1  Requester B byte accepted this cycle.
REQ-010 out_valid  output  1  Output register holds a byte.
REQ-011 out  output  WIDTH  Output register contents.
REQ-012 out_ready  input  1  Consumer accepts out this cycle.
REQ-013 sel  output  1  Mux select this cycle; 1 = A, 0 = B.
REQ-014 cnt_a  output  8  Count of accepted A transfers, wraps 255->0.
REQ-015 cnt_b  output  8  Count of accepted B transfers, wraps 255->0.

Function
REQ-016 The block SHALL share one 2:1 WIDTH-bit mux (out_mux = sel ? a : b) between requesters A and B.
REQ-017 The output stage SHALL be a one-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 load_en SHALL be the combinational term (state==EMPTY) || out_ready.
REQ-019 Grant rule: only A valid -> A; only B valid -> B; both valid -> the port not recorded in last_grant; neither -> no grant.
REQ-020 sel SHALL be 1 when A is granted or no grant is made, and 0 when B is granted.
REQ-021 a_ready SHALL be load_en && A granted; b_ready SHALL be load_en && B granted; both SHALL be combinational, never both 1.
REQ-022 When a transfer is accepted, out SHALL take the mux result and state SHALL be FULL on the next edge: one cycle of latency.
REQ-023 FULL with out_ready=1 and no grant -> EMPTY; FULL with out_ready=1 and a grant -> FULL with the new byte, giving one transfer per cycle.
REQ-024 FULL with out_ready=0 SHALL hold out, out_valid and last_grant; a_ready = b_ready = 0.
REQ-025 last_grant SHALL update only on an accepted transfer; a sole requester may win consecutive cycles.
REQ-026 Both requesters continuously valid with out_ready=1 SHALL alternate A,B,A,B... with no idle cycles.
REQ-027 cnt_a and cnt_b SHALL increment by 1 on each accepted A or B transfer, wrapping modulo 256.
REQ-028 out SHALL hold its last value when EMPTY; out is don't-care to the consumer while out_valid=0.
REQ-029 Requester data and valid SHALL be sampled only on accept; valid dropped without ready is legal and loses nothing.

Reset
REQ-030 While resetn=0 at posedge clk: state=EMPTY, out_valid=0, out=0, cnt_a=0, cnt_b=0, last_grant=B, so that A wins the first tie.
REQ-031 Reset asserted mid-transfer SHALL discard the held byte, and a_ready = b_ready = 0 in the reset cycle.

Structure
REQ-032 A shared package mux2_arb_pkg SHALL hold WIDTH_DEF=8, the state enum {EMPTY, FULL} and the grant enum {GNT_A, GNT_B}.
REQ-033 The mux SHALL be a sub-module byte_mux2 (sel ? a : b, WIDTH parameter), instantiated once.

Verification
REQ-034 After reset, A=0xaa valid, B=0xbb valid, out_ready=1 -> a_ready=1 at cycle 0; out=0xaa, 0xbb, 0xaa, 0xbb on successive cycles; cnt_a=cnt_b after an even count.
REQ-035 Only B valid with B=0xff, out_ready=1 for 4 cycles -> b_ready=1 every cycle, sel=0, out=0xff, cnt_b=4, cnt_a=0.
REQ-036 FULL holding 0xaa, out_ready=0 for 3 cycles with both valid -> out stays 0xaa, a_ready=b_ready=0; after release the next grant goes to B (0xbb).
REQ-037 resetn=0 for one cycle while FULL -> next cycle out_valid=0, out=0, counters=0; a following tie grants A.
REQ-038 257 accepted A transfers -> cnt_a=1 (wraps).
REQ-039 100 cycles of random valid/data/out_ready against a scoreboard model -> zero mismatches, with out_valid, out and each requester's data preserved in order.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester arbiter.
//   WIDTH_DEF : default data width of requester and output ports
//   state_e   : output register occupancy (EMPTY / FULL)
//   grant_e   : identity of a granted requester (GNT_A / GNT_B)
package mux2_arb_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/byte_mux2.sv
// Shared 2:1 data mux used by the arbiter.
//   sel : 1 selects a, 0 selects b
//   a   : requester A data
//   b   : requester B data
//   y   : selected data
module byte_mux2
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? a : b;

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter feeding two requesters through one shared mux into a
// one-entry output register.
//   clk       : sole clock
//   resetn    : synchronous active-low reset
//   a_valid/a : requester A handshake and data; a_ready = A accepted this cycle
//   b_valid/b : requester B handshake and data; b_ready = B accepted this cycle
//   out_valid : output register holds a word; out = its contents
//   out_ready : consumer takes out this cycle
//   sel       : mux select this cycle (1 = A, 0 = B)
//   cnt_a/b   : accepted transfer counts per requester, wrapping at 256
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready,
  output logic             sel,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b
);

  state_e           state_q, state_d;
  grant_e           last_grant_q, last_grant_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [7:0]       cnt_a_q, cnt_a_d;
  logic [7:0]       cnt_b_q, cnt_b_d;

  logic             load_en;
  logic             gnt_a, gnt_b;
  logic             accept_a, accept_b;
  logic [WIDTH-1:0] mux_y;

  // On a tie the requester that did not win last time gets the grant.
  assign gnt_a = a_valid && (!b_valid || (last_grant_q == GNT_B));
  assign gnt_b = b_valid && (!a_valid || (last_grant_q == GNT_A));

  // No grant leaves the mux pointing at A.
  assign sel = !gnt_b;

  // The register can take a new word if it is empty or being drained now.
  assign load_en = (state_q == EMPTY) || out_ready;

  // Readies are masked during reset so no requester believes its word
  // was taken while the register is being cleared.
  assign accept_a = resetn && load_en && gnt_a;
  assign accept_b = resetn && load_en && gnt_b;

  assign a_ready   = accept_a;
  assign b_ready   = accept_b;
  assign out_valid = (state_q == FULL);
  assign out       = out_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

  byte_mux2 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .sel(sel),
    .a  (a),
    .b  (b),
    .y  (mux_y)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_d        = out_q;
    cnt_a_d      = cnt_a_q;
    cnt_b_d      = cnt_b_q;

    if (accept_a || accept_b) begin
      // Load and drain can coincide, giving one transfer per cycle.
      state_d      = FULL;
      out_d        = mux_y;
      last_grant_d = accept_a ? GNT_A : GNT_B;
    end else if (out_ready) begin
      state_d = EMPTY;
    end

    if (accept_a) begin
      cnt_a_d = cnt_a_q + 8'd1;
    end
    if (accept_b) begin
      cnt_b_d = cnt_b_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= EMPTY;
      last_grant_q <= GNT_B;
      out_q        <= '0;
      cnt_a_q      <= 8'd0;
      cnt_b_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_q        <= out_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: the driver pushes the word it expects
// to be accepted; the monitor pops one word per consumer handshake.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a = 8'h00;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [7:0] b = 8'h00;
  logic       b_ready;
  logic       out_valid;
  logic [7:0] out;
  logic       out_ready = 1'b0;
  logic       sel;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  mux2_arbiter #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .a_valid  (a_valid),
    .a        (a),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b        (b),
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out      (out),
    .out_ready(out_ready),
    .sel      (sel),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One cycle: drive at negedge+1, check readies at negedge+3, return
  // at posedge+1. esel == 2 means sel is not checked.
  task automatic step(input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd,
                      input logic ordy, input logic rstn,
                      input logic ea, input logic eb, input int esel,
                      input string tag);
    @(negedge clk);
    #1;
    a_valid = av; a = ad; b_valid = bv; b = bd;
    out_ready = ordy; resetn = rstn;
    #2;
    check({tag, " a_ready"}, int'(a_ready), int'(ea));
    check({tag, " b_ready"}, int'(b_ready), int'(eb));
    if (esel != 2) check({tag, " sel"}, int'(sel), esel);
    if (!rstn) exp_q.delete();
    else begin
      if (ea) exp_q.push_back(ad);
      if (eb) exp_q.push_back(bd);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: the one-entry register is full exactly when one word is
  // outstanding; each consumer handshake retires the oldest expected word.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected output: got %02h, expected none", out);
        end else begin
          e = exp_q.pop_front();
          check("out data", int'(out), int'(e));
          $display("t=%0t out=%02h expected=%02h", $time, out, e);
        end
      end
    end
  end

  initial begin
    logic       av, bv, ordy, load, ea, eb, last_a;
    logic       m_full;
    logic [7:0] ad, bd;
    int         esel, ca, cb;

    // Reset
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, "rst");
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, "rst");
    check("rst out_valid", int'(out_valid), 0);
    check("rst out", int'(out), 0);
    check("rst cnt_a", int'(cnt_a), 0);
    check("rst cnt_b", int'(cnt_b), 0);

    // Both valid, alternating A,B,... with A first
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) step(1, 8'haa, 1, 8'hbb, 1, 1, 1, 0, 1, "alt");
      else            step(1, 8'haa, 1, 8'hbb, 1, 1, 0, 1, 0, "alt");
    end
    check("alt cnt_a", int'(cnt_a), 3);
    check("alt cnt_b", int'(cnt_b), 3);

    // Load 0xaa, stall three cycles, then B wins after release
    step(1, 8'haa, 1, 8'hbb, 1, 1, 1, 0, 1, "load");
    for (int i = 0; i < 3; i++) begin
      step(1, 8'haa, 1, 8'hbb, 0, 1, 0, 0, 2, "hold");
      check("hold out", int'(out), 8'haa);
    end
    step(1, 8'haa, 1, 8'hbb, 1, 1, 0, 1, 0, "release");
    check("release out", int'(out), 8'hbb);
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");
    check("drain out_valid", int'(out_valid), 0);
    check("drain out held", int'(out), 8'hbb);
    check("drain cnt_b", int'(cnt_b), 4);

    // Reset with both requesters valid and load possible: no ready
    step(1, 8'h12, 1, 8'h34, 1, 0, 0, 0, 2, "rstrdy");

    // B alone, four consecutive wins
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 8'hff, 1, 1, 0, 1, 0, "bonly");
    check("bonly out", int'(out), 8'hff);
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");
    check("bonly cnt_b", int'(cnt_b), 4);
    check("bonly cnt_a", int'(cnt_a), 0);

    // Reset while FULL discards the word; next tie goes to A
    step(1, 8'h5a, 0, 8'h00, 0, 1, 1, 0, 1, "fill");
    step(1, 8'h66, 1, 8'h77, 0, 0, 0, 0, 2, "rstfull");
    check("rstfull out_valid", int'(out_valid), 0);
    check("rstfull out", int'(out), 0);
    check("rstfull cnt_a", int'(cnt_a), 0);
    check("rstfull cnt_b", int'(cnt_b), 0);
    step(1, 8'h11, 1, 8'h22, 1, 1, 1, 0, 1, "tie");
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");

    // 257 A transfers: counter wraps to 1
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, "rst");
    for (int i = 0; i < 257; i++) step(1, 8'(i), 0, 8'h00, 1, 1, 1, 0, 1, "wrap");
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");
    check("wrap cnt_a", int'(cnt_a), 1);
    check("wrap cnt_b", int'(cnt_b), 0);

    // Random traffic against a reference model
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, "rst");
    last_a = 1'b0; m_full = 1'b0; ca = 0; cb = 0;
    for (int i = 0; i < 100; i++) begin
      av = 1'($urandom_range(0, 1));
      bv = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      ad = 8'($urandom_range(0, 255));
      bd = 8'($urandom_range(0, 255));
      load = !m_full || ordy;
      ea = 1'b0; eb = 1'b0; esel = 1;
      if (av && bv) begin
        if (last_a) esel = 0;
      end else if (bv) esel = 0;
      if (load && (av || bv)) begin
        if (esel == 1) ea = 1'b1;
        else           eb = 1'b1;
      end
      if (!load) esel = 2;
      step(av, ad, bv, bd, ordy, 1, ea, eb, esel, "rand");
      if (ea)        begin last_a = 1'b1; m_full = 1'b1; ca++; end
      else if (eb)   begin last_a = 1'b0; m_full = 1'b1; cb++; end
      else if (ordy) m_full = 1'b0;
    end
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");
    step(0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 1, "drain");
    check("rand cnt_a", int'(cnt_a), ca % 256);
    check("rand cnt_b", int'(cnt_b), cb % 256);
    check("queue drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
